// File: rtl/reg_bank_param.sv
// Parametrised register file: full/low/high-half write port, two registered read ports with bypass.
// Tracks pending writes per register in a scoreboard; set beats same-cycle clear.
module reg_bank_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HALF  = WIDTH / 2;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic             busy_a_q, busy_a_d;
  logic             busy_b_q, busy_b_d;
  logic             rd_valid_q;

  logic             wr_en, sb_en, zero_a, zero_b;
  logic [WIDTH-1:0] merged;

  assign wr_en  = (wr_mode != 2'b00) && !(ZR && wr_addr == '0);
  assign sb_en  = sb_set && !(ZR && sb_addr == '0);
  assign zero_a = ZR && rd_addr_a == '0;
  assign zero_b = ZR && rd_addr_b == '0;

  always_comb begin
    case (wr_mode)
      2'b01:   merged = wr_data;
      2'b10:   merged = {regs_q[wr_addr][WIDTH-1:HALF], wr_data[HALF-1:0]};
      default: merged = {wr_data[HALF-1:0], regs_q[wr_addr][HALF-1:0]};
    endcase
  end

  // Reads index the post-update state, so bypass and post-update busy fall out directly.
  always_comb begin
    regs_d      = regs_q;
    sb_d        = sb_q;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    busy_a_d    = busy_a_q;
    busy_b_d    = busy_b_q;
    if (wr_en) begin
      regs_d[wr_addr] = merged;
      sb_d[wr_addr]   = 1'b0;
    end
    if (sb_en) sb_d[sb_addr] = 1'b1;
    if (rd_en) begin
      rd_data_a_d = zero_a ? '0 : regs_d[rd_addr_a];
      rd_data_b_d = zero_b ? '0 : regs_d[rd_addr_b];
      busy_a_d    = zero_a ? 1'b0 : sb_d[rd_addr_a];
      busy_b_d    = zero_b ? 1'b0 : sb_d[rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      sb_q        <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      busy_a_q    <= 1'b0;
      busy_b_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      sb_q        <= sb_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      busy_a_q    <= busy_a_d;
      busy_b_q    <= busy_b_d;
      rd_valid_q  <= rd_en;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign busy_a    = busy_a_q;
  assign busy_b    = busy_b_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
Parametrised successor of the team's 16x32 register bank. It holds a configurable-width, configurable-depth register file with:
- one write port supporting full, low-half and high-half write modes;
- two registered read ports with a read-enable/valid handshake and write-to-read bypass;
- an optional hardwired-zero register 0;
- a per-register pending-write scoreboard.

It sits between the instruction decoder (read/scoreboard side) and the execute/writeback stage (write side).

Parameters:
WIDTH, 32, register data width in bits; must be even (half-word modes split at WIDTH/2).
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes and scoreboard sets.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_mode  in  2  00 none, 01 full word, 10 low half (upper half preserved), 11 high half (wr_data low half written to upper half; lower half preserved).
wr_addr  in  ADDR_W  write register index.
wr_data  in  WIDTH  write data.
rd_en  in  1  read request for both ports this cycle.
rd_addr_a  in  ADDR_W  port A read index.
rd_addr_b  in  ADDR_W  port B read index.
rd_data_a  out  WIDTH  registered port A data.
rd_data_b  out  WIDTH  registered port B data.
rd_valid  out  1  high for one cycle after an accepted rd_en.
busy_a  out  1  registered pending flag of rd_addr_a, captured with rd_data_a.
busy_b  out  1  registered pending flag of rd_addr_b, captured with rd_data_b.
sb_set  in  1  mark sb_addr as pending (producer issued).
sb_addr  in  ADDR_W  scoreboard index to set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers, rd_data_a/b, busy_a/b, rd_valid and all scoreboard bits go to 0 immediately;
  - reset held across edges keeps everything at 0;
  - release takes effect at the first rising edge with rst_n high.
- Write, on the rising edge when wr_mode != 00:
  - 01: reg[wr_addr] <= wr_data.
  - 10: reg <= {reg[WIDTH-1:WIDTH/2], wr_data[WIDTH/2-1:0]}.
  - 11: reg <= {wr_data[WIDTH/2-1:0], reg[WIDTH/2-1:0]}.
  - Any write (01/10/11) clears scoreboard bit wr_addr.
- Read:
  - Latency 1: rd_en sampled high at edge N gives rd_data_a/b, busy_a/b and rd_valid=1 after edge N.
  - rd_en low: rd_valid=0 and rd_data/busy hold their previous values.
- Bypass:
  - If rd_en, wr_mode != 00 and rd_addr_x == wr_addr in the same cycle, rd_data_x returns the post-write merged value (same merge as above), not the stale value.
  - busy_x in that case reflects the post-update scoreboard (see next item).
- Scoreboard:
  - sb_set sets bit sb_addr on the edge.
  - If sb_set and a write target the same address in the same cycle, set wins (new producer in flight); the bit ends at 1.
  - Different addresses update independently.
- ZERO_REG=1:
  - writes and sb_set to address 0 are ignored;
  - reads of address 0 return 0 with busy 0, bypass included.
- Both ports may read the same address; both return identical data.
- No other state; no FSM beyond the registered read stage. DEPTH x WIDTH storage plus DEPTH scoreboard flops.

Test Plan:
- Reset then full write: rst_n low mid-cycle, all outputs 0 asynchronously. Release, then wr_mode=01, wr_addr=4, wr_data=0x55555555. Next cycle rd_en=1, rd_addr_a=rd_addr_b=4 -> one cycle later rd_data_a=rd_data_b=0x55555555, rd_valid=1.
- Half writes: reg4=0x55555555. wr_mode=10, data 0xFFFFFFFF -> reg4=0x5555FFFF. wr_mode=11, data 0x0000ABCD -> reg4=0xABCDFFFF. wr_mode=00 -> unchanged.
- Bypass: same cycle wr_mode=01, wr_addr=7, wr_data=0x12345678, rd_en=1, rd_addr_a=7 -> next cycle rd_data_a=0x12345678. rd_addr_b=8 returns the old reg8.
- Scoreboard: sb_set on addr 3 -> read shows busy_a=1. Write addr 3 -> busy clears. Simultaneous sb_set and write to addr 3 -> busy stays 1 and data updated.
- ZERO_REG=1 instance: write 0xDEADBEEF to addr 0 and sb_set addr 0 -> reads of addr 0 return 0 with busy 0, including the same-cycle bypass case.
- Hold and mid-operation reset: rd_en=0 for 3 cycles -> rd_valid=0 and data unchanged. Assert rst_n low while rd_en=1 and a write are active -> all outputs 0 immediately and the write is lost.
